// File: rtl/traffic_timer.sv
// traffic_timer: interval timer for a traffic-light controller.
// A prescaler divides Clk into ticks; a saturating tick counter measured
// from the last ST (or reset) drives the TS/TL level flags. Separately,
// the side-road car sensor is synchronized and debounced into C.
module traffic_timer #(
  parameter int unsigned PRESCALE    = 4,
  parameter int unsigned SHORT_TICKS = 3,
  parameter int unsigned LONG_TICKS  = 6,
  parameter int unsigned DEBOUNCE    = 3
) (
  input  logic Clk,
  input  logic reset,
  input  logic ST,
  input  logic C_raw,
  output logic TS,
  output logic TL,
  output logic C
);

  // A PRESCALE of 1 would give a zero-width prescaler; keep one bit, held at 0.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]    SHORT_CNT  = 8'(SHORT_TICKS);
  localparam logic [7:0]    LONG_CNT   = 8'(LONG_TICKS);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          tick;

  logic          sync_meta_q, sync_meta_d;
  logic          sync_q, sync_d;
  logic [DW-1:0] deb_q, deb_d;
  logic          c_q, c_d;

  // Timer next-state: ST restarts the interval and wins over a coincident tick;
  // the tick counter stops at LONG_TICKS so TS/TL stay up until restarted.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (ST) begin
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick && (cnt_q < LONG_CNT)) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Sensor next-state: two-flop synchronizer, then C follows the synchronized
  // value only after it has disagreed with C for DEBOUNCE consecutive cycles.
  always_comb begin
    sync_meta_d = C_raw;
    sync_d      = sync_meta_q;
    deb_d       = deb_q;
    c_d         = c_q;
    if (sync_q == c_q) begin
      deb_d = '0;
    end else if (deb_q == DEB_LAST) begin
      c_d   = sync_q;
      deb_d = '0;
    end else begin
      deb_d = deb_q + DW'(1);
    end
  end

  // State registers with synchronous reset overriding ST, tick and the sensor.
  always_ff @(posedge Clk) begin
    if (reset) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      deb_q       <= '0;
      c_q         <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      deb_q       <= deb_d;
      c_q         <= c_d;
    end
  end

  // Level flags decoded purely from the registered tick count.
  always_comb begin
    TS = (cnt_q >= SHORT_CNT);
    TL = (cnt_q >= LONG_CNT);
    C  = c_q;
  end

endmodule

// File: tb/tb_traffic_timer.sv
// Scoreboard bench for traffic_timer with default parameters.
module tb_traffic_timer;

  localparam int unsigned TS_LAT = 12;  // 3 ticks * 4 clocks
  localparam int unsigned TL_LAT = 24;  // 6 ticks * 4 clocks

  logic Clk;
  logic reset;
  logic ST;
  logic C_raw;
  logic TS;
  logic TL;
  logic C;

  typedef struct packed {
    logic ts;
    logic tl;
    logic c;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned since;
  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned step_no;

  traffic_timer #(
    .PRESCALE   (4),
    .SHORT_TICKS(3),
    .LONG_TICKS (6),
    .DEBOUNCE   (3)
  ) dut (
    .Clk  (Clk),
    .reset(reset),
    .ST   (ST),
    .C_raw(C_raw),
    .TS   (TS),
    .TL   (TL),
    .C    (C)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one edge of stimulus and queue the outputs expected after it.
  task automatic step(input logic st, input logic craw, input logic rst, input logic ec);
    exp_t e;
    ST    = st;
    C_raw = craw;
    reset = rst;
    @(posedge Clk);
    if (st || rst) since = 0;
    else if (since < 10000) since++;
    e.ts = (since >= TS_LAT);
    e.tl = (since >= TL_LAT);
    e.c  = ec;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic run_idle(input int unsigned n, input logic craw, input logic ec);
    for (int unsigned i = 0; i < n; i++) step(1'b0, craw, 1'b0, ec);
  endtask

  // Monitor: every falling edge with a pending expectation, compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        step_no++;
        n_checks++;
        if (TS === e.ts) n_pass++;
        else $display("FAIL ts step %0d: got %b expected %b", step_no, TS, e.ts);
        n_checks++;
        if (TL === e.tl) n_pass++;
        else $display("FAIL tl step %0d: got %b expected %b", step_no, TL, e.tl);
        n_checks++;
        if (C === e.c) n_pass++;
        else $display("FAIL c step %0d: got %b expected %b", step_no, C, e.c);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    step_no  = 0;
    since    = 0;
    ST       = 1'b0;
    C_raw    = 1'b0;
    reset    = 1'b1;

    // Reset, then free-run from the reset release edge.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    run_idle(30, 1'b0, 1'b0);

    // Single ST pulse, then hold well past TL.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_idle(80, 1'b0, 1'b0);

    // ST pulse, re-pulse at k+30 while TS=TL=1.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_idle(29, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_idle(45, 1'b0, 1'b0);

    // ST on an edge that samples tick=1 (k+8): no increment may leak through.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_idle(7, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_idle(30, 1'b0, 1'b0);

    // ST held 20 cycles, then released.
    for (int unsigned i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    run_idle(30, 1'b0, 1'b0);

    // C_raw rises and holds: C=1 after the 5th edge; ST mid-way must not disturb C.
    for (int unsigned i = 1; i <= 12; i++)
      step(i == 8, 1'b1, 1'b0, i >= 5);
    // C_raw falls and holds: C=0 after the 5th edge.
    for (int unsigned i = 1; i <= 10; i++)
      step(1'b0, 1'b0, 1'b0, i < 5);
    // Two-cycle glitch: C stays 0.
    for (int unsigned i = 1; i <= 8; i++)
      step(1'b0, i <= 2, 1'b0, 1'b0);
    // Three-cycle pulse is just long enough: C high after edges 5..7.
    for (int unsigned i = 1; i <= 10; i++)
      step(1'b0, i <= 3, 1'b0, (i >= 5) && (i <= 7));
    // Bring C high again before the reset test.
    for (int unsigned i = 1; i <= 8; i++)
      step(1'b0, 1'b1, 1'b0, i >= 5);

    // ST at k, reset at k+15 with TS=1 and C=1; C_raw stays high.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    run_idle(14, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int unsigned i = 1; i <= 30; i++)
      step(1'b0, 1'b1, 1'b0, i >= 5);

    // Reset and ST coincident, sensor back to 0.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    run_idle(30, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int unsigned i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge Clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 Parameter PRESCALE, default 4: Clk cycles per timer tick; SHALL be >= 1.
REQ-002 Parameter SHORT_TICKS, default 3: ticks until TS asserts; SHALL be >= 1.
REQ-003 Parameter LONG_TICKS, default 6: ticks until TL asserts; SHALL satisfy SHORT_TICKS < LONG_TICKS <= 255.
REQ-004 Parameter DEBOUNCE, default 3: consecutive stable cycles needed to change C; SHALL be >= 1.
REQ-005 Clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 ST  input  1  start-timer request from the light controller, sampled each rising edge.
REQ-008 C_raw  input  1  asynchronous car-sensor input from the side-road detector.
REQ-009 TS  output  1  short interval elapsed since last ST; level.
REQ-010 TL  output  1  long interval elapsed since last ST; level.
REQ-011 C  output  1  synchronized, debounced car-present flag for the light controller.

Function
REQ-012 The prescaler SHALL count 0..PRESCALE-1 and wrap; tick SHALL be high in cycles where prescaler == PRESCALE-1.
REQ-013 The 8-bit tick counter SHALL increment on tick and saturate at LONG_TICKS with no wrap.
REQ-014 ST=1 at an edge SHALL clear prescaler and tick counter to 0 at that edge; ST SHALL take priority over a coincident tick.
REQ-015 ST held high for consecutive cycles SHALL hold both counters at 0.
REQ-016 TS SHALL equal (tick counter >= SHORT_TICKS), decoded from registered state only.
REQ-017 TL SHALL equal (tick counter >= LONG_TICKS), decoded from registered state only.
REQ-018 Latency: ST sampled at edge k (ST low afterwards) SHALL make TS rise after edge k+SHORT_TICKS*PRESCALE and TL rise after edge k+LONG_TICKS*PRESCALE.
REQ-019 TS and TL SHALL be low in the cycle after any edge that sampled ST=1.
REQ-020 TS and TL SHALL remain high until the next ST or reset, because the counter saturates.
REQ-021 C_raw SHALL pass through a two-flop synchronizer before any other use.
REQ-022 The debounce counter SHALL reset to 0 in any cycle where the synchronized value equals C, and SHALL increment otherwise.
REQ-023 C SHALL toggle to the synchronized value at the edge where the debounce counter would reach DEBOUNCE; the counter SHALL clear at that same edge.
REQ-024 A C_raw glitch shorter than DEBOUNCE cycles after synchronization SHALL NOT change C.
REQ-025 The timer path and the debounce path SHALL be independent; ST SHALL NOT affect C.

Reset
REQ-026 reset=1 at an edge SHALL clear the prescaler, tick counter, synchronizer flops and debounce counter, and set C=0; TS=0 and TL=0 from the next cycle.
REQ-027 reset SHALL override ST and tick when both are asserted at the same edge.
REQ-028 reset asserted mid-interval SHALL discard progress, and TS/TL SHALL stay low until a full interval elapses after reset is released.
REQ-029 After reset, with ST never asserted, the counter SHALL run from 0, so TS and TL assert on the REQ-018 schedule measured from the reset release edge.

Verification (PRESCALE=4, SHORT_TICKS=3, LONG_TICKS=6, DEBOUNCE=3)
REQ-030 Single ST pulse at edge k -> TS=0 through edge k+11, TS=1 after edge k+12; TL=1 after edge k+24; both stay 1 for 50 further cycles.
REQ-031 ST re-pulsed at edge k+30 with TS=TL=1 -> both 0 after edge k+30; TS=1 after edge k+42.
REQ-032 ST asserted on the cycle where tick=1 -> counter reads 0 after that edge, with no increment.
REQ-033 C_raw 0->1 held -> C=1 after 2 sync + 3 debounce edges (5 edges); a 2-cycle C_raw=1 pulse -> C stays 0.
REQ-034 reset pulsed at edge k+15 (TS=1) -> TS=TL=C=0 after that edge; TS=1 again after edge k+27.
REQ-035 Held ST for 20 cycles, then released at edge m -> TS=0 until after edge m+12.
